// File: rtl/muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared core package: operand-forwarding select and the RV32M operation
// select used by the iterative multiply/divide unit.
//   forwardCtrl_e : source select for the EX-stage operand forwarding mux
//   muldivOp_e    : RV32M operation, encoded exactly as the instruction funct3
// ---------------------------------------------------------------------------
package muldiv_unit_pkg;

  // Operand forwarding mux select driven by the hazard unit.
  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } forwardCtrl_e;

  // Encoding equals funct3 so decode can pass the field straight through.
  // Bit 2 set means a divide-class op; bit 1 within that class picks remainder.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldivOp_e;

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. Multiplies use
// radix-2 shift-add and divides use restoring division, both on operand
// magnitudes with a sign fix-up at the end. One 33-bit adder/subtractor is
// shared by both algorithms. Divide-by-zero and signed overflow finish in a
// single cycle without iterating.
// Ports:
//   clk      in   core clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   EX-stage instruction is an RV32M op with valid operands
//   flush    in   kill any in-flight operation
//   op       in   operation select (funct3 encoding)
//   rs1_data in   operand A
//   rs2_data in   operand B
//   busy     out  stall request to the hazard unit
//   done     out  one-cycle pulse, result valid
//   result   out  registered result
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  muldivOp_e       op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastStep = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  muldivOp_e       op_q, op_d;
  // opA holds the multiplicand or the divisor magnitude.
  logic [XLEN-1:0] opA_q, opA_d;
  // {acc, lo} is the double-width product / {remainder, dividend-quotient}.
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;
  logic [XLEN-1:0] result_q, result_d;

  // Incoming operand decode: which operands are signed, their magnitudes,
  // the result signs, and the two cases that finish without iterating.
  logic            signedA, signedB, rs1Neg, rs2Neg;
  logic [XLEN-1:0] rs1Mag, rs2Mag;
  logic            divByZero, signedOvf;
  logic [XLEN-1:0] specialRes;

  always_comb begin
    signedA    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                 (op == OP_DIV) || (op == OP_REM);
    signedB    = (op == OP_MUL) || (op == OP_MULH) ||
                 (op == OP_DIV) || (op == OP_REM);
    rs1Neg     = signedA & rs1_data[XLEN-1];
    rs2Neg     = signedB & rs2_data[XLEN-1];
    rs1Mag     = rs1Neg ? (~rs1_data + 1'b1) : rs1_data;
    rs2Mag     = rs2Neg ? (~rs2_data + 1'b1) : rs2_data;
    divByZero  = op[2] && (rs2_data == '0);
    signedOvf  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (rs1_data == MinNeg) && (rs2_data == '1);
    specialRes = '0;
    if (divByZero) begin
      specialRes = op[1] ? rs1_data : '1;
    end else if (signedOvf) begin
      specialRes = op[1] ? '0 : MinNeg;
    end
  end

  // Shared adder: adds the multiplicand for a multiply step, or subtracts
  // the divisor from the shifted partial remainder for a divide step.
  // The carry out of the subtraction is set when no borrow occurred.
  logic            isDivQ;
  logic [XLEN:0]   addA, addB;
  logic [XLEN+1:0] addOut;

  always_comb begin
    isDivQ = op_q[2];
    addA   = isDivQ ? {acc_q, lo_q[XLEN-1]} : {1'b0, acc_q};
    addB   = isDivQ ? ~{1'b0, opA_q} : {1'b0, opA_q};
    addOut = {1'b0, addA} + {1'b0, addB} + {{(XLEN+1){1'b0}}, isDivQ};
  end

  // One iteration of the selected algorithm, plus the sign-fixed final
  // result that is loaded when the last iteration completes.
  logic [XLEN:0]     mulSum;
  logic [XLEN-1:0]   accStep, loStep;
  logic [2*XLEN-1:0] prod, prodFix;
  logic [XLEN-1:0]   quoFix, remFix, finalRes;

  always_comb begin
    mulSum  = lo_q[0] ? addOut[XLEN:0] : {1'b0, acc_q};
    accStep = mulSum[XLEN:1];
    loStep  = {mulSum[0], lo_q[XLEN-1:1]};
    if (isDivQ) begin
      if (addOut[XLEN+1]) begin
        accStep = addOut[XLEN-1:0];
        loStep  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        accStep = addA[XLEN-1:0];
        loStep  = {lo_q[XLEN-2:0], 1'b0};
      end
    end
    prod    = {accStep, loStep};
    prodFix = negQ_q ? (~prod + 1'b1) : prod;
    quoFix  = negQ_q ? (~loStep + 1'b1) : loStep;
    remFix  = negR_q ? (~accStep + 1'b1) : accStep;
    unique case (op_q)
      OP_MUL:                        finalRes = prodFix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  finalRes = prodFix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               finalRes = quoFix;
      default:                       finalRes = remFix;
    endcase
  end

  // Next-state logic. Start is only looked at in IDLE, so a stalled EX
  // instruction is never re-issued. Flush wins over everything and leaves
  // the previous result untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opA_d    = opA_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          negQ_d = rs1Neg ^ rs2Neg;
          negR_d = rs1Neg;
          acc_d  = '0;
          cnt_d  = '0;
          opA_d  = op[2] ? rs2Mag : rs1Mag;
          lo_d   = op[2] ? rs1Mag : rs2Mag;
          if (divByZero || signedOvf) begin
            result_d = specialRes;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d = accStep;
        lo_d  = loStep;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) begin
          result_d = finalRes;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers; reset clears everything including the
  // held result, so an in-flight operation is simply discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      opA_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opA_q    <= opA_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      result_q <= result_d;
    end
  end

  // The stall request covers the issuing cycle and every iteration, and
  // drops in DONE so the pipeline advances exactly once per operation.
  assign busy   = (state_q == CALC) || ((state_q == IDLE) && start);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed-vector bench for muldiv_unit with hand-computed expected results,
// latencies and stall lengths, plus flush and mid-operation reset scenarios.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  muldivOp_e   op;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vecCount = 0;
  int errCount = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .rs1_data (rs1Data),
    .rs2_data (rs2Data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence itself ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one operation for a single cycle, then measures the cycles to the
  // done pulse and the stall length, and checks the result and its holding.
  task automatic applyStimulus(input string tag, input muldivOp_e o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input int expLat);
    int cycles;
    int busyCycles;
    bit seen;
    @(negedge clk);
    op      = o;
    rs1Data = a;
    rs2Data = b;
    start   = 1'b1;
    #1;
    busyCycles = busy ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (busy) busyCycles++;
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_lat"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_busy"}, 32'(busyCycles), 32'(expLat));
    checkOutput({tag, "_res"}, result, expRes);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_hold"}, result, expRes);
  endtask

  // Watches a window of cycles and checks that no done pulse appears.
  task automatic watchNoDone(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    op      = OP_MUL;
    rs1Data = '0;
    rs2Data = '0;
    #1;
    checkOutput("rst_result", result, 32'h0000_0000);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Multiply family.
    applyStimulus("mul_7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    applyStimulus("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    applyStimulus("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    applyStimulus("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    applyStimulus("mulh_min2", OP_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33);
    applyStimulus("mul_trunc", OP_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);

    // Divide family.
    applyStimulus("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    applyStimulus("rem_m7d2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    applyStimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    applyStimulus("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    applyStimulus("rem_7dm2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

    // Single-cycle special cases.
    applyStimulus("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("rem_by0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    applyStimulus("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Flush partway through a divide; previous result (0) must be kept,
    // so run one non-zero op first to make the hold observable.
    applyStimulus("pre_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk);
    op      = OP_DIV;
    rs1Data = 32'd1000;
    rs2Data = 32'd3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy_after", 32'(busy), 32'd0);
    checkOutput("flush_done", 32'(done), 32'd0);
    checkOutput("flush_result", result, 32'd14);
    watchNoDone("flush_no_done", 40);
    checkOutput("flush_result_late", result, 32'd14);
    applyStimulus("post_flush", OP_DIV, 32'd1000, 32'd3, 32'd333, 33);

    // Asynchronous reset at cycle 20 of a multiply.
    @(negedge clk);
    op      = OP_MUL;
    rs1Data = 32'd9;
    rs2Data = 32'd9;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_result", result, 32'h0000_0000);
    checkOutput("rstmid_done", 32'(done), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watchNoDone("rstmid_no_done", 40);
    checkOutput("rstmid_result_late", result, 32'h0000_0000);
    applyStimulus("post_reset", OP_MUL, 32'd9, 32'd9, 32'd81, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  EX-stage instruction is an RV32M op; operands valid.
REQ-005 SHALL have port: flush  input  1  kill the in-flight operation (branch/trap redirect).
REQ-006 SHALL have port: op  input  muldivOp_e  operation select.
REQ-007 SHALL have port: rs1_data  input  32  forwarded operand A, from the operand-forwarding mux.
REQ-008 SHALL have port: rs2_data  input  32  forwarded operand B, from the operand-forwarding mux.
REQ-009 SHALL have port: busy  output  1  stall request to the hazard unit; freeze IF/ID/EX.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: result  output  32  registered result to the EX/MEM register.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, capture op and operands at the edge; a special case goes to DONE, any other op goes to CALC with the iteration counter at 0.
REQ-014 SHALL, in CALC, perform one shift-add multiply or restoring-divide step per cycle on operand magnitudes, and go to DONE after the 32nd step.
REQ-015 SHALL, on entering DONE, load result with its sign fixed up; done=1 only in DONE; DONE always returns to IDLE on the next edge.
REQ-016 SHALL drive busy=1 in CALC, and in IDLE when start=1 (combinational); busy=0 in DONE and otherwise, so the pipeline advances exactly once.
REQ-017 SHALL ignore start in CALC and DONE, so the same EX instruction is never re-issued.
REQ-018 SHALL give normal ops a latency where start sampled at edge N gives done=1 in the cycle after edge N+33.
REQ-019 SHALL give special cases a latency where start sampled at edge N gives done=1 in the cycle after edge N+1, with no CALC.
REQ-020 SHALL produce MUL as the low 32 bits of the product, and MULH/MULHSU/MULHU as the high 32 bits, with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-021 SHALL make DIV/REM truncate toward zero, with the remainder taking the sign of the dividend; DIVU/REMU are unsigned.
REQ-022 SHALL treat divide by zero as a special case: quotient 0xFFFFFFFF and remainder = rs1_data, for both signed and unsigned ops.
REQ-023 SHALL treat signed overflow (0x80000000 / 0xFFFFFFFF) as a special case: DIV gives 0x80000000 and REM gives 0.
REQ-024 SHALL, when flush=1 in any state, go to IDLE at the next edge with no done pulse and result unchanged; flush overrides start in the same cycle.
REQ-025 SHALL hold result between operations; it changes only on entry to DONE.
REQ-026 SHALL never leave busy asserted for more than 33 consecutive cycles for one operation.

Reset
REQ-027 SHALL, with rst_n=0, immediately force: state IDLE, counter 0, done 0, result 0x00000000, and all internal operand/accumulator registers 0.
REQ-028 SHALL make busy=start after reset (IDLE behaviour); a reset mid-CALC discards the operation.

Structure
REQ-029 SHALL define muldivOp_e in the shared core package next to forwardCtrl_e, encoded as funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-030 SHALL define the FSM state enum locally in the module; no package constant beyond muldivOp_e.
REQ-031 SHALL be implemented as a single module with no sub-module; one shared 33-bit adder/subtractor serves both multiply and divide.

Verification
REQ-032 SHALL cover: MUL, rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start, busy high for 33 cycles.
REQ-033 SHALL cover: MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000; MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover: DIV, -7 / 2 -> 0xFFFFFFFD; REM, -7, 2 -> 0xFFFFFFFF; DIVU, 100 / 7 -> 14.
REQ-035 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF, REM 5,0 -> 5, and DIV 0x80000000/0xFFFFFFFF -> 0x80000000, each with done 1 cycle after start.
REQ-036 SHALL cover: DIV started, flush pulsed at cycle 10 -> no done pulse, busy=0 next cycle, result keeps its prior value; a new start then completes correctly.
REQ-037 SHALL cover: rst_n dropped at cycle 20 of a MUL -> outputs at reset values immediately, no done pulse after release.
